// File: rtl/uart_pkg.sv
// Shared types, parity-mode constants and baud helper for the UART receive path.
// With UART_RX_BREAK_DET_EN defined the state enum also carries ST_BRK_WAIT.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef UART_RX_BREAK_DET_EN
    , ST_BRK_WAIT
`endif
  } uart_state_t;

  // Rounded NCO increment giving oversample*baud ticks per second from f_clk.
  function automatic logic [15:0] baud_inc_calc(input longint f_clk, input longint baud,
                                                input longint oversample);
    longint num;
    num = (baud * oversample * 65536 + f_clk / 2) / f_clk;
    return num[15:0];
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Received-word stream: data word plus its status flags, valid/ready handshake.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (output m_data, m_valid, frame_err, parity_err, input m_ready);
  modport slave  (input m_data, m_valid, frame_err, parity_err, output m_ready);
endinterface

// File: rtl/uart_baud_nco.sv
// Phase-accumulator baud generator; the registered carry-out is the oversample tick.
module uart_baud_nco
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baud_inc,
  output logic        tick
);

  logic [15:0] acc;
  logic [16:0] sum;

  assign sum = {1'b0, acc} + {1'b0, baud_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[15:0];
      tick <= sum[16];
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-vote filter and valid/ready output.
// Optional break detection enabled by defining UART_RX_BREAK_DET_EN.
//
// state       | meaning
// ST_IDLE     | waiting for line high (arm), then a low sample (start)
// ST_START    | confirming start bit at mid-bit
// ST_DATA     | shifting in data bits, LSB first
// ST_PARITY   | capturing parity bit
// ST_STOP     | checking stop bit(s)
// ST_BRK_WAIT | break seen, waiting for line to return high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rxd,
  input  logic [15:0]           baud_inc,
  uart_rx_core_if.master        m_if,
  output logic                  overrun,
  output logic                  break_det,
  output logic                  busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] START_SMP = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] BIT_SMP   = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

  logic tick;
  logic sync1, sync2, rx_bit;
  logic [2:0] maj_sr;

  uart_state_t state, state_nxt;
  logic [OS_W-1:0]      os_cnt, os_cnt_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic pbit, pbit_nxt;
  logic ferr_acc, ferr_nxt;
  logic all_zero, zero_nxt;
  logic armed, armed_nxt;
  logic done_q, done_nxt;
  logic brk_nxt;
  logic sample;
  logic par_err_c;

  uart_baud_nco u_nco (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_inc (baud_inc),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      maj_sr <= 3'b111;
      rx_bit <= 1'b1;
    end else begin
      sync1  <= rxd;
      sync2  <= sync1;
      if (tick) maj_sr <= {maj_sr[1:0], sync2};
      rx_bit <= (maj_sr[0] & maj_sr[1]) | (maj_sr[0] & maj_sr[2]) | (maj_sr[1] & maj_sr[2]);
    end
  end

  assign sample = tick && (os_cnt == ((state == ST_START) ? START_SMP : BIT_SMP));
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    os_cnt_nxt  = os_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    pbit_nxt    = pbit;
    ferr_nxt    = ferr_acc;
    zero_nxt    = all_zero;
    armed_nxt   = armed;
    done_nxt    = 1'b0;
    brk_nxt     = 1'b0;
    if (state != ST_IDLE && tick) os_cnt_nxt = sample ? '0 : os_cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        if (rx_bit) armed_nxt = 1'b1;
        else if (armed && tick) begin
          state_nxt  = ST_START;
          os_cnt_nxt = '0;
          armed_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (sample) begin
          if (rx_bit) state_nxt = ST_IDLE;
          else begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            zero_nxt    = 1'b1;
            ferr_nxt    = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_nxt = {rx_bit, shreg[DATA_BITS-1:1]};
          if (rx_bit) zero_nxt = 1'b0;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          pbit_nxt  = rx_bit;
          if (rx_bit) zero_nxt = 1'b0;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (rx_bit) zero_nxt = 1'b0;
          else        ferr_nxt = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
            if (zero_nxt) begin
              done_nxt  = 1'b0;
              brk_nxt   = 1'b1;
              state_nxt = ST_BRK_WAIT;
            end
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BRK_WAIT: begin
        if (rx_bit) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pbit     <= 1'b0;
      ferr_acc <= 1'b0;
      all_zero <= 1'b0;
      armed    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      os_cnt   <= os_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      pbit     <= pbit_nxt;
      ferr_acc <= ferr_nxt;
      all_zero <= zero_nxt;
      armed    <= armed_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    par_err_c = 1'b0;
    if (PARITY == PAR_EVEN)     par_err_c = (^shreg) ^ pbit;
    else if (PARITY == PAR_ODD) par_err_c = ~((^shreg) ^ pbit);
  end

  // A completed word is dropped rather than overwriting one the consumer has not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_if.m_data     <= '0;
      m_if.m_valid    <= 1'b0;
      m_if.frame_err  <= 1'b0;
      m_if.parity_err <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (m_if.m_valid && !m_if.m_ready) begin
          overrun <= 1'b1;
        end else begin
          m_if.m_data     <= shreg;
          m_if.m_valid    <= 1'b1;
          m_if.frame_err  <= ferr_acc;
          m_if.parity_err <= par_err_c;
        end
      end else if (m_if.m_valid && m_if.m_ready) begin
        m_if.m_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) break_det <= 1'b0;
    else        break_det <= brk_nxt;
  end
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench: two receivers (no parity / even parity) fed from per-frame reference model.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int DB      = 8;
  localparam int CPB     = 434;
  localparam int CPB_FST = 128;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd0 = 1'b1;
  logic        rxd1 = 1'b1;
  logic [15:0] baud_inc = 16'd0;
  logic        ovr0, ovr1, brk0, brk1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int total = 0;
  int bad = 0;
  int ovr_cnt0 = 0, ovr_cnt1 = 0, brk_cnt0 = 0, brk_cnt1 = 0;
  int exp_brk0 = 0, exp_brk1 = 0;
  int rdy_mode = 1;
  int ovr_base, brk_base;

  uart_rx_core_if #(.DATA_BITS(DB)) if0 ();
  uart_rx_core_if #(.DATA_BITS(DB)) if1 ();

  uart_rx_core #(.DATA_BITS(DB), .PARITY(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd0), .baud_inc(baud_inc), .m_if(if0.master),
    .overrun(ovr0), .break_det(brk0), .busy(busy0)
  );

  uart_rx_core #(.DATA_BITS(DB), .PARITY(PAR_EVEN), .STOP_BITS(1), .OVERSAMPLE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd1), .baud_inc(baud_inc), .m_if(if1.master),
    .overrun(ovr1), .break_det(brk1), .busy(busy1)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       begin if0.m_ready = 1'b0; if1.m_ready = 1'b0; end
      2:       begin if0.m_ready = 1'($urandom); if1.m_ready = 1'($urandom); end
      default: begin if0.m_ready = 1'b1; if1.m_ready = 1'b1; end
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && if0.m_valid && if0.m_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 unexpected word: got 0x%0h expected none", if0.m_data);
      end else begin
        e0 = q0.pop_front();
        check("dut0 word {data,ferr,perr}", 32'({if0.m_data, if0.frame_err, if0.parity_err}), 32'(e0));
      end
    end
    if (rst_n && if1.m_valid && if1.m_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected word: got 0x%0h expected none", if1.m_data);
      end else begin
        e1 = q1.pop_front();
        check("dut1 word {data,ferr,perr}", 32'({if1.m_data, if1.frame_err, if1.parity_err}), 32'(e1));
      end
    end
    if (ovr0) ovr_cnt0++;
    if (ovr1) ovr_cnt1++;
    if (brk0) brk_cnt0++;
    if (brk1) brk_cnt1++;
  end

  // Reference: word, stop-bit framing and even parity straight from the frame contents.
  task automatic expect_frame(input int which, input logic [7:0] d, input logic pb, input logic sb);
    exp_t e;
    bit brk, brk_en;
    brk_en = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_en = 1'b1;
`endif
    e.data = d;
    e.ferr = ~sb;
    e.perr = (which == 1) ? ((^d) ^ pb) : 1'b0;
    brk = (d == 8'h00) && ((which == 0) || !pb) && !sb;
    if (brk && brk_en) begin
      if (which == 0) exp_brk0++; else exp_brk1++;
    end else begin
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic hold_bit(input int which, input logic v, input int n);
    #1;
    if (which == 0) rxd0 = v; else rxd1 = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pb, input logic sb,
                            input int cpb);
    hold_bit(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) hold_bit(which, d[i], cpb);
    if (which == 1) hold_bit(which, pb, cpb);
    hold_bit(which, sb, cpb);
    hold_bit(which, 1'b1, cpb);
  endtask

  task automatic frame(input int which, input logic [7:0] d, input logic pb, input logic sb,
                       input int cpb);
    expect_frame(which, d, pb, sb);
    send_frame(which, d, pb, sb, cpb);
  endtask

  initial begin
    logic [7:0] d;
    logic pb, sb;
    int which;
    baud_inc = baud_inc_calc(50_000_000, 115200, 16);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("baud_inc_calc 50MHz/115200x16", 32'(baud_inc), 32'd2416);
    check("reset m_valid0", 32'(if0.m_valid), 32'd0);
    check("reset m_data0", 32'(if0.m_data), 32'd0);
    check("reset flags0", 32'({if0.frame_err, if0.parity_err, ovr0, brk0}), 32'd0);
    check("reset busy0/busy1", 32'({busy0, busy1}), 32'd0);
    check("reset m_valid1", 32'(if1.m_valid), 32'd0);
    repeat (CPB) @(posedge clk);

    frame(0, 8'hA5, 1'b0, 1'b1, CPB);
    check("A5 delivered", 32'(q0.size()), 32'd0);

    frame(1, 8'h3C, 1'b1, 1'b1, CPB);
    frame(1, 8'h3C, 1'b0, 1'b1, CPB);
    check("3C parity words delivered", 32'(q1.size()), 32'd0);

    hold_bit(0, 1'b0, 108);
    hold_bit(0, 1'b1, 2 * CPB);
    check("glitch busy0", 32'(busy0), 32'd0);
    check("glitch m_valid0", 32'(if0.m_valid), 32'd0);

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    ovr_base = ovr_cnt0;
    frame(0, 8'h11, 1'b0, 1'b1, CPB);
    check("held m_valid0", 32'(if0.m_valid), 32'd1);
    check("held m_data0 after 11", 32'(if0.m_data), 32'h11);
    send_frame(0, 8'h22, 1'b0, 1'b1, CPB);
    check("m_data0 kept after overrun", 32'(if0.m_data), 32'h11);
    check("overrun pulses", 32'(ovr_cnt0 - ovr_base), 32'd1);
    rdy_mode = 1;
    repeat (5) @(posedge clk);
    check("11 drained", 32'(q0.size()), 32'd0);

    brk_base = brk_cnt0;
    expect_frame(0, 8'h00, 1'b0, 1'b0);
    hold_bit(0, 1'b0, 20 * CPB);
    hold_bit(0, 1'b1, 2 * CPB);
    check("break word queue", 32'(q0.size()), 32'd0);
    check("break_det pulses", 32'(brk_cnt0 - brk_base), 32'(exp_brk0));

    ovr_base = ovr_cnt0;
    brk_base = brk_cnt0;
    hold_bit(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_bit(0, 1'(8'h5A >> i), CPB);
    hold_bit(0, 1'b1, CPB / 2);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("in reset busy0", 32'(busy0), 32'd0);
    check("in reset m_valid0", 32'(if0.m_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("after reset m_valid0", 32'(if0.m_valid), 32'd0);
    check("after reset pulses", 32'((ovr_cnt0 - ovr_base) + (brk_cnt0 - brk_base)), 32'd0);
    frame(0, 8'h81, 1'b0, 1'b1, CPB);
    check("81 delivered", 32'(q0.size()), 32'd0);

    baud_inc = 16'd8192;
    rdy_mode = 2;
    repeat (4 * CPB_FST) @(posedge clk);
    for (int n = 0; n < 10; n++) begin
      which = n % 2;
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      frame(which, d, pb, sb, CPB_FST);
    end
    rdy_mode = 1;
    repeat (2 * CPB_FST) @(posedge clk);

    check("final q0 empty", 32'(q0.size()), 32'd0);
    check("final q1 empty", 32'(q1.size()), 32'd0);
    check("final overrun0 count", 32'(ovr_cnt0), 32'd1);
    check("final overrun1 count", 32'(ovr_cnt1), 32'd0);
    check("final break0 count", 32'(brk_cnt0), 32'(exp_brk0));
    check("final break1 count", 32'(brk_cnt1), 32'(exp_brk1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 DATA_BITS, 8, data word width; legal 5..9.
REQ-002 PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 STOP_BITS, 1, stop bits checked; legal 1 or 2.
REQ-004 OVERSAMPLE, 16, sample ticks per bit; power of two, 8..32.
REQ-005 clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 rxd  in  1  serial line, asynchronous to clk, idle high.
REQ-008 baud_inc  in  16  NCO increment; tick rate = f_clk*baud_inc/2^16 = OVERSAMPLE*baud.
REQ-009 m_data  out  DATA_BITS  received word, LSB first on line.
REQ-010 m_valid  out  1  word available; held until m_ready.
REQ-011 m_ready  in  1  consumer accepts word when m_valid&&m_ready.
REQ-012 frame_err, parity_err  out  1 each  status of the word in m_data, valid with m_valid.
REQ-013 overrun  out  1  one-clk pulse when a completed word is dropped.
REQ-014 break_det  out  1  one-clk pulse on break (tied 0 without macro).
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 NCO: 16-bit accumulator adds baud_inc each clk; registered carry-out is tick; baud_inc=0 -> no ticks, FSM frozen.
REQ-017 rxd passes a 2-flop synchronizer; a 3-bit shift register loads on tick; rx_bit = 2-of-3 majority, registered.
REQ-018 States: IDLE, START, DATA, PARITY, STOP, plus BRK_WAIT under macro.
REQ-019 IDLE arms only after rx_bit=1 is seen; armed and rx_bit=0 on a tick -> START, os_cnt=0.
REQ-020 os_cnt increments on tick outside IDLE; START samples at os_cnt=OVERSAMPLE/2-1; DATA/PARITY/STOP sample at OVERSAMPLE-1; os_cnt clears on each sample.
REQ-021 START sample rx_bit=1 -> IDLE (false start, nothing reported); 0 -> DATA.
REQ-022 DATA: DATA_BITS samples shifted in LSB first; then PARITY if PARITY!=0, else STOP.
REQ-023 Parity error: even -> XOR(data,pbit)=1; odd -> XOR(data,pbit)=0; PARITY state skipped when PARITY=0.
REQ-024 STOP: STOP_BITS samples; any 0 sets frame_err for the word; FSM leaves STOP after the last stop sample regardless.
REQ-025 Completion: m_data, frame_err, parity_err, m_valid load 1 clk after the final stop sample.
REQ-026 If m_valid=1 and m_ready=0 at completion: word dropped, held word unchanged, overrun pulses 1 clk.
REQ-027 Completion coinciding with m_valid&&m_ready: new word loads, m_valid stays 1, no overrun.
REQ-028 m_valid clears on m_valid&&m_ready with no completion in that clk.
REQ-029 baud_inc change takes effect next clk, including mid-frame; no FSM reset.

Reset
REQ-030 rst_n low asynchronously clears NCO, synchronizer (to 1), majority register (to 1), os_cnt, bit counter, FSM to IDLE unarmed, m_data=0, all status outputs 0.
REQ-031 Reset mid-frame discards the partial word; no output pulses on release.

Configuration
REQ-032 Macro UART_RX_BREAK_DET_EN.
REQ-033 Defined: frame with all data, parity and stop samples 0 -> no word delivered, break_det pulses 1 clk, FSM enters BRK_WAIT until rx_bit=1, then IDLE.
REQ-034 Undefined: same frame delivered as data 0 with frame_err=1; break_det constant 0; BRK_WAIT absent.

Structure
REQ-035 Package uart_pkg: FSM state enum, parity-mode constants (PAR_NONE/EVEN/ODD), baud_inc helper function for f_clk, baud, OVERSAMPLE.
REQ-036 Sub-module uart_baud_nco: accumulator and tick; reusable by the transmitter.

Verification
REQ-037 f_clk 50 MHz, baud_inc 2416 (115200x16), PARITY 0, byte 0xA5 -> m_data 0xA5, m_valid 1, no error flags.
REQ-038 PARITY 1, byte 0x3C with parity bit 1 -> m_data 0x3C, parity_err 1; with bit 0 -> parity_err 0.
REQ-039 rxd low pulse of 4 ticks in IDLE -> no m_valid, FSM back to IDLE, busy low.
REQ-040 Two bytes 0x11, 0x22 with m_ready held 0 -> m_data stays 0x11, overrun pulses once at second word end.
REQ-041 Line held low 20 bit times, macro defined -> one break_det pulse, no m_valid; undefined -> m_data 0x00, frame_err 1, one word only.
REQ-042 rst_n asserted at data bit 4 of 0x5A, then byte 0x81 -> only 0x81 delivered, no error flags.
